// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-8 sequential multiplier controller.
// Holds the FSM state encoding, multiple-register select codes and step-count helper.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE3,
    PRE5,
    PRE7,
    RUN,
    DONE
  } stateT;

  localparam logic [1:0] PRE_NONE = 2'b00;
  localparam logic [1:0] PRE_3M   = 2'b01;
  localparam logic [1:0] PRE_5M   = 2'b10;
  localparam logic [1:0] PRE_7M   = 2'b11;

  localparam int STEP_W = 4;

  // One step per 3-bit digit, rounding up so a partial top digit still gets a step.
  function automatic int calcNsteps(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/mult_digit_shifter.sv
// Loadable right shift register that presents the multiplier 3 bits at a time, LSB first.
// Load wins over Shift; Digit is the registered low digit, valid the cycle after Load/Shift.
module mult_digit_shifter #(
  parameter int W = 33
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic         Shift,
  input  logic [W-1:0] D,
  output logic [2:0]   Digit
);

  logic [W-1:0] shReg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shReg <= '0;
    end else if (Load) begin
      shReg <= D;
    end else if (Shift) begin
      shReg <= shReg >> 3;
    end
  end

  assign Digit = shReg[2:0];

endmodule

// File: rtl/mult_seq_controller.sv
// Sequencer for the radix-8 multiplier: three precompute cycles (3M/5M/7M) then one RUN step per digit.
// Start accepted only in IDLE; Busy spans cycles 1..3+NSTEPS, Done pulses in cycle 4+NSTEPS; no Start queuing.
module mult_seq_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [WIDTH-1:0]  Multiplier,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        MuxSel,
  output logic              PreWrEn,
  output logic [1:0]        PreSel,
  output logic              AccClr,
  output logic              AccEn,
  output logic              ShiftEn,
  output logic [STEP_W-1:0] StepCnt
);

  localparam int                NSTEPS = calcNsteps(WIDTH);
  localparam int                SH_W   = 3 * NSTEPS;
  localparam logic [STEP_W-1:0] LAST   = STEP_W'(NSTEPS - 1);

  stateT             state;
  stateT             stateNxt;
  logic [STEP_W-1:0] stepCnt;
  logic [2:0]        digit;
  logic              accept;

  assign accept = (state == IDLE) && Start;

  // Zero-extension pads the top digit so bits above WIDTH read as 0.
  mult_digit_shifter #(
    .W (SH_W)
  ) uShifter (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (accept),
    .Shift (state == RUN),
    .D     (SH_W'(Multiplier)),
    .Digit (digit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      stepCnt <= '0;
    end else begin
      state <= stateNxt;
      if (state == RUN && stepCnt != LAST) begin
        stepCnt <= stepCnt + 1'b1;
      end else begin
        stepCnt <= '0;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    MuxSel   = 3'd0;
    PreWrEn  = 1'b0;
    PreSel   = PRE_NONE;
    AccClr   = 1'b0;
    AccEn    = 1'b0;
    ShiftEn  = 1'b0;
    StepCnt  = '0;
    case (state)
      IDLE: begin
        if (Start) stateNxt = PRE3;
      end
      PRE3: begin
        Busy     = 1'b1;
        PreWrEn  = 1'b1;
        PreSel   = PRE_3M;
        AccClr   = 1'b1;
        stateNxt = PRE5;
      end
      PRE5: begin
        Busy     = 1'b1;
        PreWrEn  = 1'b1;
        PreSel   = PRE_5M;
        stateNxt = PRE7;
      end
      PRE7: begin
        Busy     = 1'b1;
        PreWrEn  = 1'b1;
        PreSel   = PRE_7M;
        stateNxt = RUN;
      end
      RUN: begin
        Busy    = 1'b1;
        AccEn   = 1'b1;
        ShiftEn = 1'b1;
        MuxSel  = digit;
        StepCnt = stepCnt;
        if (stepCnt == LAST) stateNxt = DONE;
      end
      DONE: begin
        Done     = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_controller.sv
// Randomized bench for mult_seq_controller against a cycle-phase reference model.
// Model: phase 0 = idle, 1..15 = cycles after an accepted Start (WIDTH=32, NSTEPS=11).
module tb_mult_seq_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Multiplier = '0;
  logic        Busy, Done, PreWrEn, AccClr, AccEn, ShiftEn;
  logic [2:0]  MuxSel;
  logic [1:0]  PreSel;
  logic [3:0]  StepCnt;

  int          checks = 0;
  int          errors = 0;
  int          phase = 0;
  logic [63:0] latchedM = '0;

  mult_seq_controller #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Multiplier (Multiplier),
    .Busy       (Busy),
    .Done       (Done),
    .MuxSel     (MuxSel),
    .PreWrEn    (PreWrEn),
    .PreSel     (PreSel),
    .AccClr     (AccClr),
    .AccEn      (AccEn),
    .ShiftEn    (ShiftEn),
    .StepCnt    (StepCnt)
  );

  always #5 Clk = ~Clk;

  // Output vector: Busy,Done,MuxSel,PreWrEn,PreSel,AccClr,AccEn,ShiftEn,StepCnt
  function automatic logic [14:0] obs();
    return {Busy, Done, MuxSel, PreWrEn, PreSel, AccClr, AccEn, ShiftEn, StepCnt};
  endfunction

  function automatic logic [14:0] expv();
    logic       run, pre;
    logic [2:0] mux;
    logic [1:0] ps;
    logic [3:0] sc;
    run = (phase >= 4) && (phase <= 14);
    pre = (phase >= 1) && (phase <= 3);
    ps  = pre ? 2'(phase) : 2'b00;
    mux = run ? 3'((latchedM >> (3 * (phase - 4))) & 64'd7) : 3'd0;
    sc  = run ? 4'(phase - 4) : 4'd0;
    return {(phase >= 1 && phase <= 14), (phase == 15), mux, pre, ps,
            (phase == 1), run, run, sc};
  endfunction

  // Advance one clock; the model sees the same Start/Multiplier the DUT sampled.
  task automatic step();
    logic        s;
    logic [31:0] m;
    s = Start;
    m = Multiplier;
    @(posedge Clk);
    if (phase == 0) begin
      if (s) begin
        phase    = 1;
        latchedM = {32'd0, m};
      end
    end else if (phase == 15) begin
      phase = 0;
    end else begin
      phase++;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs(), 15'd0);
    end
    Reset = 1'b0;
    phase = 0;
    step();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL idle_after_reset got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_pattern(input logic [31:0] m);
    int accCnt, doneCnt;
    accCnt = 0;
    doneCnt = 0;
    Start = 1'b1;
    Multiplier = m;
    step();
    Start = 1'b0;
    Multiplier = $urandom;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL pattern_%h cyc %0d got %h exp %h", m, c, obs(), expv());
      end
      if (AccEn) accCnt++;
      if (Done) doneCnt++;
      step();
    end
    checks++;
    if (accCnt != 11 || doneCnt != 1) begin
      errors++;
      $display("FAIL pattern_counts_%h acc %0d done %0d exp acc 11 done 1", m, accCnt, doneCnt);
    end
  endtask

  task automatic test_reset_mid_run();
    Start = 1'b1;
    Multiplier = $urandom;
    step();
    Start = 1'b0;
    while (phase != 9) step();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL async_reset_mid_run got %h exp %h", obs(), 15'd0);
    end
    phase = 0;
    #1 Reset = 1'b0;
    step();
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL no_resume_after_reset got %h exp %h", obs(), 15'd0);
    end
    test_pattern(32'h0000_0001);
  endtask

  task automatic test_start_ignored();
    int preCnt;
    preCnt = 0;
    Start = 1'b1;
    Multiplier = 32'h0BAD_F00D;
    step();
    Start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL start_ignored cyc %0d got %h exp %h", c, obs(), expv());
      end
      if (PreWrEn) preCnt++;
      Start = (c == 2 || c == 9 || c == 15);
      Multiplier = $urandom;
      step();
    end
    Start = 1'b0;
    checks++;
    if (preCnt != 3) begin
      errors++;
      $display("FAIL start_ignored_prewr got %0d exp 3", preCnt);
    end
  endtask

  task automatic test_back_to_back();
    int doneAt[$];
    Start = 1'b1;
    Multiplier = 32'h1234_5678;
    step();
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %h exp %h", c, obs(), expv());
      end
      if (Done) doneAt.push_back(c);
      Start = (c < 39);
      Multiplier = $urandom;
      step();
    end
    Start = 1'b0;
    checks++;
    if (doneAt.size() != 2 || doneAt[0] != 15 || doneAt[1] != 31) begin
      errors++;
      $display("FAIL back_to_back_done count %0d first %0d exp 2 at 15 and 31",
               doneAt.size(), (doneAt.size() > 0) ? doneAt[0] : -1);
    end
    for (int c = 0; c < 20 && phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL back_to_back_drain got %h exp %h", obs(), expv());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      Start = ($urandom_range(0, 3) == 0);
      Multiplier = $urandom;
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", c, obs(), expv());
      end
    end
    Start = 1'b0;
    while (phase != 0) step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_pattern(32'h0000_00FA);
    test_pattern(32'hFFFF_FFFF);
    test_pattern(32'h0000_0000);
    test_pattern(32'h8000_0000);
    for (int i = 0; i < 4; i++) test_pattern($urandom);
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
